// File: rtl/asic_iopoc_seq.sv
// Padring power-on-control sequencer: qualifies the IO supply, holds poc while
// segments are enabled one at a time with a programmable dwell, and drops all on supply loss.
module asic_iopoc_seq #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          vddio_ok,
    input  logic [N-1:0]  en_mask,
    input  logic [CW-1:0] delay,
    output logic          poc,
    output logic [N-1:0]  seg_en,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RAMP, DONE} state_t;

    // A programmed dwell of zero still costs one cycle per step.
    function automatic logic [CW-1:0] sat_dwell(input logic [CW-1:0] dl);
        return (dl == '0) ? CW'(1) : dl;
    endfunction

    state_t        state, state_n;
    logic          ok_p0, ok_s;
    logic [CW-1:0] cnt, cnt_n, cnt_inc, dwell;
    logic [IW-1:0] idx, idx_n;
    logic [N-1:0]  seg_n;
    logic          fault_n, step_hit;

    assign dwell    = sat_dwell(delay);
    assign cnt_inc  = cnt + 1'b1;
    assign step_hit = (cnt_inc == dwell);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        seg_n   = seg_en;
        fault_n = fault;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
            seg_n   = '0;
            fault_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = WAIT;
                    cnt_n   = '0;
                    seg_n   = '0;
                end
                WAIT: begin
                    if (!ok_s) begin
                        cnt_n = '0;
                    end else if (step_hit) begin
                        state_n = RAMP;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                RAMP: begin
                    if (!ok_s) begin
                        state_n = WAIT;
                        cnt_n   = '0;
                        idx_n   = '0;
                        seg_n   = '0;
                        fault_n = 1'b1;
                    end else if (!en_mask[idx] || step_hit) begin
                        // Skipped segments complete in one cycle; enabled ones after the dwell.
                        if (en_mask[idx]) seg_n[idx] = 1'b1;
                        cnt_n = '0;
                        if (idx == LAST) begin
                            state_n = DONE;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                DONE: begin
                    if (!ok_s) begin
                        state_n = WAIT;
                        cnt_n   = '0;
                        idx_n   = '0;
                        seg_n   = '0;
                        fault_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Sync stage p0 -> ok_s, then state and registered outputs; poc releases
    // only once DONE has been held for a full cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ok_p0  <= 1'b0;
            ok_s   <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            seg_en <= '0;
            poc    <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            fault  <= 1'b0;
        end else begin
            ok_p0  <= vddio_ok;
            ok_s   <= ok_p0;
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            seg_en <= seg_n;
            poc    <= !((state == DONE) && (state_n == DONE));
            busy   <= (state_n == WAIT) || (state_n == RAMP);
            done   <= (state_n == DONE);
            fault  <= fault_n;
        end
    end

endmodule
